row_result_collector: RTL and testbench

- Many-to-one counterpart of the row/column broadcast bus: gathers one result word per PE from a row of ARRAY_SIZE processing elements and serialises them onto a single valid/ready stream toward the result buffer.
- On a collect pulse it snapshots all PE outputs plus a per-PE valid mask, then drains only the valid entries, lowest index first, under downstream backpressure.

---
 rtl/row_bus_pkg.sv | 24 ++
 rtl/lane_ffs.sv | 28 ++
 rtl/row_result_collector.sv | 134 +++++++++++++
 tb/tb_row_result_collector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/row_bus_pkg.sv
// Shared definitions for the row broadcast/collect buses: FSM encoding,
// a constant clog2 for parameter checks, and the lane slice-offset helper.
package row_bus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Ceiling log2 with a floor of 1, so a single-lane row still has a 1-bit index
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Low bit offset of a lane inside a packed multi-lane vector
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/lane_ffs.sv
// Priority find-first-set over a lane mask. Lowest set bit wins.
// Purely combinational; reports found, index, one-hot and single-bit-set.
module lane_ffs #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [WIDTH-1:0]     mask,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] index,
  output logic [WIDTH-1:0]     onehot,
  output logic                 single
);

  // Scan upward and lock onto the first set bit
  always_comb begin
    found  = 1'b0;
    index  = '0;
    onehot = mask & (~mask + 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i] && !found) begin
        found = 1'b1;
        index = IDX_WIDTH'(i);
      end
    end
    single = found && ((mask & (mask - 1'b1)) == '0);
  end

endmodule

// File: rtl/row_result_collector.sv
// Row result collector: snapshots one result word per PE on ap_collect and
// drains the valid lanes, lowest index first, onto a valid/ready stream.
// Optional feature macro: COLLECT_OVERRUN_EN (sticky overrun flag on
// ap_collect while busy, with overrun_clr).
module row_result_collector
  import row_bus_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ap_collect,
  input  logic [ARRAY_SIZE-1:0]        pe_valid,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_in,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [IDX_WIDTH-1:0]         out_idx,
`ifdef COLLECT_OVERRUN_EN
  input  logic                         overrun_clr,
  output logic                         overrun,
`endif
  output logic                         out_last
);

  generate
    if (IDX_WIDTH < clog2(ARRAY_SIZE)) begin : g_bad_idx_width
      $error("IDX_WIDTH too narrow for ARRAY_SIZE");
    end
  endgenerate

  state_e                          state_q, state_d;
  logic [ARRAY_SIZE-1:0]           mask_q, mask_d;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_q, data_d;

  logic                  ffs_found;
  logic [IDX_WIDTH-1:0]  ffs_index;
  logic [ARRAY_SIZE-1:0] ffs_onehot;
  logic                  ffs_single;
  logic                  xfer;

  logic [DATA_WIDTH-1:0] lane_word [ARRAY_SIZE];

  lane_ffs #(
    .WIDTH     (ARRAY_SIZE),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_ffs (
    .mask   (mask_q),
    .found  (ffs_found),
    .index  (ffs_index),
    .onehot (ffs_onehot),
    .single (ffs_single)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      assign lane_word[gi] = data_q[lane_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
    end
  endgenerate

  // Stream outputs come straight from the snapshot, so they hold under backpressure
  always_comb begin
    busy      = (state_q == ST_DRAIN);
    out_valid = (state_q == ST_DRAIN) && ffs_found;
    out_last  = out_valid && ffs_single;
    out_idx   = ffs_index;
    out_data  = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (ffs_onehot[i]) out_data = out_data | lane_word[i];
    end
  end

  assign xfer = out_valid && out_ready;

  // Next state: capture in IDLE, retire one lane per accepted beat in DRAIN
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_collect && (pe_valid != '0)) begin
          state_d = ST_DRAIN;
          mask_d  = pe_valid;
          data_d  = data_in;
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          mask_d = mask_q & ~ffs_onehot;
          if (ffs_single) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and snapshot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

`ifdef COLLECT_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: a capture request arriving mid-drain; set beats clear
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (ap_collect && busy) overrun_d = 1'b1;
  end

  // Overrun flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_row_result_collector.sv
// Directed self-checking bench for row_result_collector.
module tb_row_result_collector;

  localparam int AS = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic             ap_collect;
  logic [AS-1:0]    pe_valid;
  logic [AS*DW-1:0] data_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
`ifdef COLLECT_OVERRUN_EN
  logic             overrun_clr;
  logic             overrun;
`endif

  int n_cmp;
  int n_fail;
  int xfer_count;

  row_result_collector #(
    .ARRAY_SIZE (AS),
    .DATA_WIDTH (DW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ap_collect (ap_collect),
    .pe_valid   (pe_valid),
    .data_in    (data_in),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
`ifdef COLLECT_OVERRUN_EN
    .overrun_clr(overrun_clr),
    .overrun    (overrun),
`endif
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer monitor: one line per accepted beat
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfer_count++;
      $display("beat idx=%0d data=%h last=%b", out_idx, out_data, out_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", out_last); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", out_data); end
    n_cmp++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
`ifdef COLLECT_OVERRUN_EN
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_drain();
    logic [DW-1:0] exp_data [4];
    exp_data[0] = 16'hAAAA; exp_data[1] = 16'hBBBB;
    exp_data[2] = 16'hCCCC; exp_data[3] = 16'hDDDD;
    pe_valid   = 4'b1111;
    data_in    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    out_ready  = 1'b1;
    ap_collect = 1'b1;
    tick();
    ap_collect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid beat=%0d got=%b exp=1", k, out_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy beat=%0d got=%b exp=1", k, busy); end
      n_cmp++; if (out_idx !== IW'(k)) begin n_fail++; $display("FAIL full_idx beat=%0d got=%0d exp=%0d", k, out_idx, k); end
      n_cmp++; if (out_data !== exp_data[k]) begin n_fail++; $display("FAIL full_data beat=%0d got=%h exp=%h", k, out_data, exp_data[k]); end
      n_cmp++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL full_last beat=%0d got=%b exp=%b", k, out_last, (k == 3)); end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got=%b exp=0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure_overrun();
    int x0;
    pe_valid   = 4'b1010;
    data_in    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    out_ready  = 1'b0;
    ap_collect = 1'b1;
    tick();
    ap_collect = 1'b0;
    x0 = xfer_count;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, out_valid); end
      n_cmp++; if (out_idx !== 2'd1) begin n_fail++; $display("FAIL bp_idx cyc=%0d got=%0d exp=1", c, out_idx); end
      n_cmp++; if (out_data !== 16'hBBBB) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%h exp=bbbb", c, out_data); end
      n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL bp_last cyc=%0d got=%b exp=0", c, out_last); end
      // Attempt a second capture while the first snapshot is still draining
      if (c == 1) begin
        ap_collect = 1'b1;
        pe_valid   = 4'b1111;
        data_in    = {4{16'h1111}};
      end else begin
        ap_collect = 1'b0;
      end
      if (c == 3) out_ready = 1'b1;
      tick();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp2_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_idx !== 2'd3) begin n_fail++; $display("FAIL bp2_idx got=%0d exp=3", out_idx); end
    n_cmp++; if (out_data !== 16'hDDDD) begin n_fail++; $display("FAIL bp2_data got=%h exp=dddd", out_data); end
    n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL bp2_last got=%b exp=1", out_last); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_end got=%b exp=0", out_valid); end
    n_cmp++; if (xfer_count - x0 !== 2) begin n_fail++; $display("FAIL bp_xfers got=%0d exp=2", xfer_count - x0); end
`ifdef COLLECT_OVERRUN_EN
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    tick();
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr got=%b exp=0", overrun); end
`endif
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_empty_collect();
    pe_valid   = 4'b0000;
    data_in    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    out_ready  = 1'b1;
    ap_collect = 1'b1;
    tick();
    ap_collect = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy cyc=%0d got=%b exp=0", c, busy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid cyc=%0d got=%b exp=0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    pe_valid   = 4'b1111;
    data_in    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    out_ready  = 1'b1;
    ap_collect = 1'b1;
    tick();
    ap_collect = 1'b0;
    n_cmp++; if (out_data !== 16'hAAAA) begin n_fail++; $display("FAIL mid_first got=%h exp=aaaa", out_data); end
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    pe_valid   = 4'b0100;
    data_in    = {16'h9999, 16'h5555, 16'h7777, 16'h3333};
    ap_collect = 1'b1;
    tick();
    ap_collect = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL post_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_idx !== 2'd2) begin n_fail++; $display("FAIL post_idx got=%0d exp=2", out_idx); end
    n_cmp++; if (out_data !== 16'h5555) begin n_fail++; $display("FAIL post_data got=%h exp=5555", out_data); end
    n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL post_last got=%b exp=1", out_last); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_end_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_end_busy got=%b exp=0", busy); end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    xfer_count = 0;
    rst        = 1'b0;
    ap_collect = 1'b0;
    pe_valid   = '0;
    data_in    = '0;
    out_ready  = 1'b0;
`ifdef COLLECT_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    test_reset();
    test_full_drain();
    test_backpressure_overrun();
    test_empty_collect();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
